// File: rtl/sr_drv_pkg.sv
// Shared opcodes, error codes, FSM state type and counter-width helper for sr_latch_driver.
package sr_drv_pkg;

  localparam logic [1:0] OP_NOP = 2'b00;
  localparam logic [1:0] OP_RST = 2'b01;
  localparam logic [1:0] OP_SET = 2'b10;
  localparam logic [1:0] OP_ILL = 2'b11;

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_ILL  = 2'b01;
  localparam logic [1:0] ERR_TMO  = 2'b10;
  localparam logic [1:0] ERR_FB   = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_CHECK = 2'd2
  } state_t;

  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/sr_drv_cnt.sv
// Loadable saturating down-counter with zero flag; load takes priority over decrement.
module sr_drv_cnt
  import sr_drv_pkg::*;
#(
  parameter int MAX = 1,
  parameter int W   = cnt_width(MAX)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic         o_zero
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/sr_latch_driver.sv
// Command-side SR latch driver: pulses s or r for PULSE_W cycles, then confirms q/q_bar.
// Optional macro SR_DRV_RETRY_EN re-drives up to MAX_RETRY times after a feedback timeout.
module sr_latch_driver
  import sr_drv_pkg::*;
#(
  parameter int PULSE_W   = 2,
  parameter int TIMEOUT   = 8,
  parameter int MAX_RETRY = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  input  logic [1:0] req_op,
  output logic       req_ready,
  output logic       s,
  output logic       r,
  input  logic       q_fb,
  input  logic       q_bar_fb,
  output logic       done,
  output logic       err,
  output logic [1:0] err_code,
  output logic       busy
);

  localparam int CMAX = (PULSE_W > TIMEOUT) ? PULSE_W : TIMEOUT;
  localparam int CW   = cnt_width(CMAX);
  localparam logic [CW-1:0] LD_PULSE = CW'(PULSE_W - 1);
  localparam logic [CW-1:0] LD_TMO   = CW'(TIMEOUT - 1);

`ifdef SR_DRV_RETRY_EN
  localparam int RETRIES = MAX_RETRY;
`else
  // With retries disabled the retry counter is loaded with zero, so MAX_RETRY has no effect.
  localparam int RETRIES = 0 * MAX_RETRY;
`endif
  localparam int RW = cnt_width(RETRIES);
  localparam logic [RW-1:0] LD_RTY = RW'(RETRIES);

  state_t     r_state, w_state_nxt;
  logic       r_target, w_target_nxt;
  logic       r_s, r_r, r_done, r_err;
  logic [1:0] r_err_code;

  logic       w_s_nxt, w_r_nxt, w_done_nxt, w_err_nxt;
  logic [1:0] w_code_nxt;
  logic       w_cnt_load, w_cnt_dec, w_cnt_zero;
  logic [CW-1:0] w_cnt_val;
  logic       w_rty_load, w_rty_dec, w_rty_zero;

  logic w_ready, w_hs, w_is_drive_op, w_op_tgt, w_already, w_match, w_bad;

  assign w_ready       = (r_state == ST_IDLE) && !r_done && !r_err;
  assign w_hs          = req_valid && w_ready;
  assign w_is_drive_op = (req_op == OP_SET) || (req_op == OP_RST);
  assign w_op_tgt      = (req_op == OP_SET);
  assign w_already     = (q_fb == w_op_tgt) && (q_bar_fb != q_fb);
  assign w_match       = (q_fb == r_target) && (q_bar_fb == ~r_target);
  assign w_bad         = (q_fb == q_bar_fb);

  sr_drv_cnt #(.MAX(CMAX), .W(CW)) u_cnt (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_cnt_load),
    .i_load_val (w_cnt_val),
    .i_dec      (w_cnt_dec),
    .o_zero     (w_cnt_zero)
  );

  sr_drv_cnt #(.MAX(RETRIES), .W(RW)) u_rty (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_rty_load),
    .i_load_val (LD_RTY),
    .i_dec      (w_rty_dec),
    .o_zero     (w_rty_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_target   <= 1'b0;
      r_s        <= 1'b0;
      r_r        <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_err_code <= ERR_NONE;
    end else begin
      r_state    <= w_state_nxt;
      r_target   <= w_target_nxt;
      r_s        <= w_s_nxt;
      r_r        <= w_r_nxt;
      r_done     <= w_done_nxt;
      r_err      <= w_err_nxt;
      r_err_code <= w_code_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_target_nxt = r_target;
    unique case (r_state)
      ST_IDLE: begin
        if (w_hs && w_is_drive_op && !w_already) begin
          w_state_nxt  = ST_DRIVE;
          w_target_nxt = w_op_tgt;
        end
      end
      ST_DRIVE: begin
        if (w_cnt_zero) w_state_nxt = ST_CHECK;
      end
      ST_CHECK: begin
        if (w_match || w_bad) begin
          w_state_nxt = ST_IDLE;
        end else if (w_cnt_zero) begin
          w_state_nxt = w_rty_zero ? ST_IDLE : ST_DRIVE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Registered outputs are computed one cycle ahead, so s/r follow the state transitions.
  always_comb begin
    w_s_nxt    = 1'b0;
    w_r_nxt    = 1'b0;
    w_done_nxt = 1'b0;
    w_err_nxt  = 1'b0;
    w_code_nxt = ERR_NONE;
    w_cnt_load = 1'b0;
    w_cnt_val  = '0;
    w_cnt_dec  = 1'b0;
    w_rty_load = 1'b0;
    w_rty_dec  = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_hs) begin
          if (req_op == OP_NOP) begin
            w_done_nxt = 1'b1;
          end else if (req_op == OP_ILL) begin
            w_err_nxt  = 1'b1;
            w_code_nxt = ERR_ILL;
          end else if (w_already) begin
            w_done_nxt = 1'b1;
          end else begin
            w_s_nxt    = w_op_tgt;
            w_r_nxt    = ~w_op_tgt;
            w_cnt_load = 1'b1;
            w_cnt_val  = LD_PULSE;
            w_rty_load = 1'b1;
          end
        end
      end
      ST_DRIVE: begin
        if (w_cnt_zero) begin
          w_cnt_load = 1'b1;
          w_cnt_val  = LD_TMO;
        end else begin
          w_s_nxt   = r_target;
          w_r_nxt   = ~r_target;
          w_cnt_dec = 1'b1;
        end
      end
      ST_CHECK: begin
        if (w_match) begin
          w_done_nxt = 1'b1;
        end else if (w_bad) begin
          w_err_nxt  = 1'b1;
          w_code_nxt = ERR_FB;
        end else if (w_cnt_zero) begin
          if (!w_rty_zero) begin
            w_rty_dec  = 1'b1;
            w_cnt_load = 1'b1;
            w_cnt_val  = LD_PULSE;
            w_s_nxt    = r_target;
            w_r_nxt    = ~r_target;
          end else begin
            w_err_nxt  = 1'b1;
            w_code_nxt = ERR_TMO;
          end
        end else begin
          w_cnt_dec = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign req_ready = w_ready;
  assign s         = r_s;
  assign r         = r_r;
  assign done      = r_done;
  assign err       = r_err;
  assign err_code  = r_err_code;
  assign busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_sr_latch_driver.sv
// Self-checking bench for sr_latch_driver with a clocked SR flip-flop model on s/r/q.
module tb_sr_latch_driver;
  import sr_drv_pkg::*;

  localparam int PW  = 2;
  localparam int TMO = 4;
`ifdef SR_DRV_RETRY_EN
  localparam int RETRIES = 1;
`else
  localparam int RETRIES = 0;
`endif
  localparam int ATT     = 1 + RETRIES;
  localparam int TMO_LAT = ATT * (PW + TMO) + 1;

  localparam int M_NORM = 0;
  localparam int M_ST0  = 1;
  localparam int M_ST1  = 2;
  localparam int M_B11  = 3;
  localparam int M_B00  = 4;

  typedef struct {
    logic [1:0] op;
    int         mode;
    logic       q0;
    logic       e_done;
    logic       e_err;
    logic [1:0] e_code;
    int         e_lat;
    int         e_s;
    int         e_r;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req_valid = 1'b0;
  logic [1:0] req_op = 2'b00;
  logic req_ready, s, r, q_fb, q_bar_fb, done, err, busy;
  logic [1:0] err_code;

  logic q_lat = 1'b0;
  logic preset_en = 1'b0;
  logic preset_val = 1'b0;
  int   fb_mode = M_NORM;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  sr_latch_driver #(.PULSE_W(PW), .TIMEOUT(TMO), .MAX_RETRY(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_op    (req_op),
    .req_ready (req_ready),
    .s         (s),
    .r         (r),
    .q_fb      (q_fb),
    .q_bar_fb  (q_bar_fb),
    .done      (done),
    .err       (err),
    .err_code  (err_code),
    .busy      (busy)
  );

  always @(posedge clk) begin
    if (preset_en)    q_lat <= preset_val;
    else if (s && !r) q_lat <= 1'b1;
    else if (r && !s) q_lat <= 1'b0;
  end

  always_comb begin
    case (fb_mode)
      M_NORM:  {q_fb, q_bar_fb} = {q_lat, ~q_lat};
      M_ST0:   {q_fb, q_bar_fb} = 2'b01;
      M_ST1:   {q_fb, q_bar_fb} = 2'b10;
      M_B11:   {q_fb, q_bar_fb} = 2'b11;
      default: {q_fb, q_bar_fb} = 2'b00;
    endcase
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic vec_t predict(input logic [1:0] op, input int mode, input logic q0);
    vec_t v;
    logic tgt, fq, fqb;
    int att;
    v.op = op; v.mode = mode; v.q0 = q0;
    v.e_done = 1'b0; v.e_err = 1'b0; v.e_code = 2'b00; v.e_lat = 1; v.e_s = 0; v.e_r = 0;
    case (mode)
      M_NORM:  {fq, fqb} = {q0, ~q0};
      M_ST0:   {fq, fqb} = 2'b01;
      M_ST1:   {fq, fqb} = 2'b10;
      M_B11:   {fq, fqb} = 2'b11;
      default: {fq, fqb} = 2'b00;
    endcase
    if (op == OP_NOP) begin
      v.e_done = 1'b1;
    end else if (op == OP_ILL) begin
      v.e_err = 1'b1; v.e_code = ERR_ILL;
    end else begin
      tgt = (op == OP_SET);
      if (fq == tgt && fqb != fq) begin
        v.e_done = 1'b1;
      end else begin
        att = (mode == M_ST0 || mode == M_ST1) ? ATT : 1;
        if (tgt) v.e_s = PW * att; else v.e_r = PW * att;
        if (mode == M_NORM) begin
          v.e_done = 1'b1; v.e_lat = PW + 2;
        end else if (mode == M_B11 || mode == M_B00) begin
          v.e_err = 1'b1; v.e_code = ERR_FB; v.e_lat = PW + 2;
        end else begin
          v.e_err = 1'b1; v.e_code = ERR_TMO; v.e_lat = att * (PW + TMO) + 1;
        end
      end
    end
    return v;
  endfunction

  task automatic run_txn(input vec_t v, input string tag);
    int lat = 0, ns = 0, nr = 0, both = 0, rdy_bad = 0, nbusy = 0;
    logic g_done = 1'b0, g_err = 1'b0;
    logic [1:0] g_code = 2'b00;
    @(negedge clk);
    fb_mode = v.mode; preset_val = v.q0; preset_en = 1'b1;
    @(negedge clk);
    preset_en = 1'b0;
    req_valid = 1'b1; req_op = v.op;
    chk({tag, ".ready_pre"}, int'(req_ready), 1);
    @(posedge clk);
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      if (n == 1) begin
        req_valid = 1'b0;
        req_op = 2'($urandom_range(0, 3));
      end
      if (s) ns++;
      if (r) nr++;
      if (s && r) both++;
      if (req_ready) rdy_bad++;
      if (busy) nbusy++;
      if (done || err) begin
        lat = n; g_done = done; g_err = err; g_code = err_code;
        break;
      end
    end
    chk({tag, ".latency"}, lat, v.e_lat);
    chk({tag, ".done"}, int'(g_done), int'(v.e_done));
    chk({tag, ".err"}, int'(g_err), int'(v.e_err));
    if (v.e_err) chk({tag, ".err_code"}, int'(g_code), int'(v.e_code));
    chk({tag, ".s_cycles"}, ns, v.e_s);
    chk({tag, ".r_cycles"}, nr, v.e_r);
    chk({tag, ".s_and_r"}, both, 0);
    chk({tag, ".ready_busy"}, rdy_bad, 0);
    chk({tag, ".busy_cycles"}, nbusy, v.e_lat - 1);
    @(negedge clk);
    chk({tag, ".pulse_end"}, int'(done || err), 0);
    chk({tag, ".ready_post"}, int'(req_ready), 1);
    if (v.mode == M_NORM && (v.op == OP_SET || v.op == OP_RST))
      chk({tag, ".q_final"}, int'(q_lat), int'(v.op == OP_SET));
  endtask

  vec_t vecs[10];

  initial begin
    vecs[0] = '{OP_SET, M_NORM, 1'b0, 1'b1, 1'b0, ERR_NONE, 4, 2, 0};
    vecs[1] = '{OP_RST, M_NORM, 1'b0, 1'b1, 1'b0, ERR_NONE, 1, 0, 0};
    vecs[2] = '{OP_ILL, M_NORM, 1'b0, 1'b0, 1'b1, ERR_ILL,  1, 0, 0};
    vecs[3] = '{OP_NOP, M_NORM, 1'b1, 1'b1, 1'b0, ERR_NONE, 1, 0, 0};
    vecs[4] = '{OP_SET, M_ST0,  1'b0, 1'b0, 1'b1, ERR_TMO,  TMO_LAT, 2 * ATT, 0};
    vecs[5] = '{OP_SET, M_B11,  1'b0, 1'b0, 1'b1, ERR_FB,   4, 2, 0};
    vecs[6] = '{OP_RST, M_NORM, 1'b1, 1'b1, 1'b0, ERR_NONE, 4, 0, 2};
    vecs[7] = '{OP_RST, M_ST1,  1'b1, 1'b0, 1'b1, ERR_TMO,  TMO_LAT, 0, 2 * ATT};
    vecs[8] = '{OP_RST, M_B00,  1'b1, 1'b0, 1'b1, ERR_FB,   4, 0, 2};
    vecs[9] = '{OP_SET, M_NORM, 1'b1, 1'b1, 1'b0, ERR_NONE, 1, 0, 0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset.s", int'(s), 0);
    chk("reset.r", int'(r), 0);
    chk("reset.done", int'(done), 0);
    chk("reset.err", int'(err), 0);
    chk("reset.err_code", int'(err_code), 0);
    chk("reset.busy", int'(busy), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("reset.ready", int'(req_ready), 1);

    for (int i = 0; i < 10; i++) run_txn(vecs[i], $sformatf("vec%0d", i));

    // reset while s is being driven
    @(negedge clk);
    fb_mode = M_NORM; preset_val = 1'b0; preset_en = 1'b1;
    @(negedge clk);
    preset_en = 1'b0; req_valid = 1'b1; req_op = OP_SET;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk("rstmid.s_before", int'(s), 1);
    #2 rst = 1'b1;
    #1;
    chk("rstmid.s_async", int'(s), 0);
    chk("rstmid.r_async", int'(r), 0);
    chk("rstmid.busy", int'(busy), 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    begin
      int pulses = 0;
      for (int n = 0; n < 8; n++) begin
        @(negedge clk);
        if (done || err || s || r) pulses++;
      end
      chk("rstmid.no_activity", pulses, 0);
    end
    chk("rstmid.q_kept", int'(q_lat), 0);
    run_txn(vecs[0], "rstmid.next");

    for (int i = 0; i < 40; i++) begin
      logic [1:0] op;
      int m, sel;
      logic q0;
      op  = 2'($urandom_range(0, 3));
      sel = int'($urandom_range(0, 9));
      m   = (sel < 6) ? M_NORM : sel - 5;
      q0  = 1'($urandom_range(0, 1));
      run_txn(predict(op, m, q0), $sformatf("rnd%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
